// File: rtl/pic8259.sv
// Simplified 8259A interrupt controller: IRQ edge latching, fixed priority
// (bit 0 highest), ICW/OCW programming over the IO bus and the two-pulse
// INTA handshake that returns the vector byte on oData.
//
// Bus handshake: a write acts once, on the first cycle (iCS & iWR) is seen
// high after being low; reads and the vector byte are level based and
// registered into oData every cycle.
module pic8259 #(
  parameter logic [7:0] VECTOR_RESET = 8'h08,
  parameter logic [7:0] IMR_RESET    = 8'hFF
) (
  input  logic       iClk,
  input  logic       iRst,
  input  logic       iCS,
  input  logic       iWR,
  input  logic       iRD,
  input  logic       iA0,
  input  logic [7:0] iData,
  output logic [7:0] oData,
  input  logic [7:0] iIrq,
  output logic       oInt,
  input  logic       iIntA
);

  typedef enum logic [1:0] {INIT_READY, INIT_ICW2, INIT_ICW3, INIT_ICW4} init_state_t;
  typedef enum logic [1:0] {ACK_IDLE, ACK_1, ACK_2, ACK_2_DONE} ack_state_t;

  init_state_t init_state, init_n;
  ack_state_t  ack_state, ack_n;

  logic [7:0] irr, isr, imr, irr_n, isr_n, imr_n;
  logic [4:0] base, base_n;
  logic       aeoi, aeoi_n, read_isr, read_isr_n;
  logic       sngl, sngl_n, ic4, ic4_n;
  logic [2:0] vec_idx, vec_n;
  logic       spurious, spur_n;
  logic [7:0] irq_prev;
  logic       inta_prev, wr_prev;
  logic [7:0] data_n;

  logic       wr_level, wr_pulse, icw1, inta_fall, inta_rise, int_req;
  logic [7:0] irq_rise, pending, pend_low, isr_low, ack_set, eoi_clr;

  // Index of the lowest set bit (highest priority); 0 when nothing is set.
  function automatic logic [2:0] lowest_index(input logic [7:0] v);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (v[i]) idx = 3'(i);
    end
    return idx;
  endfunction

  // Edge detection and priority helpers.
  always_comb begin
    wr_level  = iCS & iWR;
    wr_pulse  = wr_level & ~wr_prev;
    icw1      = wr_pulse & ~iA0 & iData[4];
    irq_rise  = iIrq & ~irq_prev;
    inta_fall = inta_prev & ~iIntA;
    inta_rise = ~inta_prev & iIntA;
    pending   = irr & ~imr;
    pend_low  = pending & (~pending + 8'd1);
    isr_low   = isr & (~isr + 8'd1);
    // Bits below the highest-priority in-service bit; all ones when ISR=0.
    int_req   = |(pending & (isr_low - 8'd1));
  end

  // Next-state logic for the init FSM, ack FSM, IRR/ISR/IMR and read data.
  always_comb begin
    init_n     = init_state;
    ack_n      = ack_state;
    imr_n      = imr;
    base_n     = base;
    aeoi_n     = aeoi;
    read_isr_n = read_isr;
    sngl_n     = sngl;
    ic4_n      = ic4;
    vec_n      = vec_idx;
    spur_n     = spurious;
    ack_set    = 8'd0;
    eoi_clr    = 8'd0;

    case (ack_state)
      ACK_IDLE: begin
        if (inta_fall) begin
          ack_n = ACK_1;
          if (pending == 8'd0) begin
            vec_n  = 3'd7;
            spur_n = 1'b1;
          end else begin
            vec_n   = lowest_index(pending);
            spur_n  = 1'b0;
            ack_set = pend_low;
          end
        end
      end
      ACK_1: begin
        if (inta_fall) ack_n = ACK_2;
      end
      ACK_2: begin
        if (inta_rise) begin
          ack_n = ACK_IDLE;
          if (aeoi && !spurious) eoi_clr = 8'd1 << vec_idx;
        end
      end
      default: ack_n = ACK_IDLE;
    endcase

    if (wr_pulse && !icw1) begin
      case (init_state)
        INIT_READY: begin
          if (iA0) begin
            imr_n = iData;
          end else if (!iData[3]) begin
            case (iData[7:5])
              3'b001:  eoi_clr = eoi_clr | isr_low;
              3'b011:  eoi_clr = eoi_clr | (8'd1 << iData[2:0]);
              default: ;
            endcase
          end else if (iData[1]) begin
            read_isr_n = iData[0];
          end
        end
        INIT_ICW2: begin
          if (iA0) begin
            base_n = iData[7:3];
            if (!sngl)    init_n = INIT_ICW3;
            else if (ic4) init_n = INIT_ICW4;
            else          init_n = INIT_READY;
          end
        end
        INIT_ICW3: begin
          if (iA0) init_n = ic4 ? INIT_ICW4 : INIT_READY;
        end
        default: begin
          if (iA0) begin
            aeoi_n = iData[1];
            init_n = INIT_READY;
          end
        end
      endcase
    end

    // An IRQ edge beats the ack clear; an EOI clear is applied before the ack set.
    irr_n = (irr & ~ack_set) | irq_rise;
    isr_n = (isr & ~eoi_clr) | ack_set;

    // ICW1 overrides every other event in the same cycle.
    if (icw1) begin
      imr_n      = 8'd0;
      isr_n      = 8'd0;
      irr_n      = 8'd0;
      read_isr_n = 1'b0;
      ack_n      = ACK_IDLE;
      sngl_n     = iData[1];
      ic4_n      = iData[0];
      init_n     = INIT_ICW2;
    end

    if (iCS && iRD)                      data_n = iA0 ? imr : (read_isr ? isr : irr);
    else if (ack_state == ACK_2 && !iIntA) data_n = {base, vec_idx};
    else                                 data_n = 8'd0;
  end

  // State registers with synchronous reset.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      init_state <= INIT_READY;
      ack_state  <= ACK_IDLE;
      irr        <= 8'd0;
      isr        <= 8'd0;
      imr        <= IMR_RESET;
      base       <= VECTOR_RESET[7:3];
      aeoi       <= 1'b0;
      read_isr   <= 1'b0;
      sngl       <= 1'b0;
      ic4        <= 1'b0;
      vec_idx    <= 3'd0;
      spurious   <= 1'b0;
      irq_prev   <= 8'd0;
      inta_prev  <= 1'b1;
      wr_prev    <= 1'b0;
      oData      <= 8'd0;
      oInt       <= 1'b0;
    end else begin
      init_state <= init_n;
      ack_state  <= ack_n;
      irr        <= irr_n;
      isr        <= isr_n;
      imr        <= imr_n;
      base       <= base_n;
      aeoi       <= aeoi_n;
      read_isr   <= read_isr_n;
      sngl       <= sngl_n;
      ic4        <= ic4_n;
      vec_idx    <= vec_n;
      spurious   <= spur_n;
      irq_prev   <= iIrq;
      inta_prev  <= iIntA;
      wr_prev    <= wr_level;
      oData      <= data_n;
      oInt       <= int_req && (ack_n != ACK_1);
    end
  end

endmodule

// File: tb/tb_pic8259.sv
// Self-checking bench for pic8259: a transaction-level model pushes expected
// read bytes, vector bytes and INT levels into a queue as stimulus is driven;
// each observation pops the queue and compares.
module tb_pic8259;

  logic       iClk = 1'b0;
  logic       iRst = 1'b1;
  logic       iCS = 1'b0, iWR = 1'b0, iRD = 1'b0, iA0 = 1'b0;
  logic [7:0] iData = 8'd0;
  logic [7:0] oData;
  logic [7:0] iIrq = 8'd0;
  logic       oInt;
  logic       iIntA = 1'b1;

  int checks = 0;
  int failures = 0;
  logic [7:0] exp_q[$];

  // model state
  logic [7:0] m_irr, m_isr, m_imr;
  logic [4:0] m_base;
  logic       m_aeoi, m_rsel, m_sngl, m_ic4, m_spur;
  int         m_init;
  logic [2:0] m_n;

  pic8259 dut (
    .iClk(iClk), .iRst(iRst), .iCS(iCS), .iWR(iWR), .iRD(iRD), .iA0(iA0),
    .iData(iData), .oData(oData), .iIrq(iIrq), .oInt(oInt), .iIntA(iIntA)
  );

  // clock / reset
  always #5 iClk = ~iClk;

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check_val(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%02h expected 0x%02h", tag, obs, exp);
    end
  endtask

  task automatic sb_check(input string tag, input logic [7:0] obs);
    if (exp_q.size() == 0) check_val({tag, "_sb_empty"}, 8'd0, 8'd1);
    else check_val(tag, obs, exp_q.pop_front());
  endtask

  function automatic logic model_int();
    for (int i = 0; i < 8; i++) begin
      if (m_isr[i]) return 1'b0;
      if (m_irr[i] && !m_imr[i]) return 1'b1;
    end
    return 1'b0;
  endfunction

  task automatic model_reset();
    m_irr = 8'd0; m_isr = 8'd0; m_imr = 8'hFF; m_base = 5'd1;
    m_aeoi = 1'b0; m_rsel = 1'b0; m_sngl = 1'b0; m_ic4 = 1'b0;
    m_spur = 1'b0; m_init = 0; m_n = 3'd0;
    exp_q.delete();
  endtask

  task automatic model_write(input logic a0, input logic [7:0] d);
    if (!a0 && d[4]) begin
      m_imr = 8'd0; m_isr = 8'd0; m_irr = 8'd0; m_rsel = 1'b0;
      m_sngl = d[1]; m_ic4 = d[0]; m_init = 1;
    end else begin
      case (m_init)
        0: begin
          if (a0) m_imr = d;
          else if (!d[3]) begin
            if (d[7:5] == 3'b001) begin
              for (int i = 0; i < 8; i++) begin
                if (m_isr[i]) begin m_isr[i] = 1'b0; break; end
              end
            end else if (d[7:5] == 3'b011) begin
              m_isr[d[2:0]] = 1'b0;
            end
          end else if (d[1]) m_rsel = d[0];
        end
        1: if (a0) begin
          m_base = d[7:3];
          m_init = !m_sngl ? 2 : (m_ic4 ? 3 : 0);
        end
        2: if (a0) m_init = m_ic4 ? 3 : 0;
        default: if (a0) begin m_aeoi = d[1]; m_init = 0; end
      endcase
    end
  endtask

  // driver tasks
  task automatic do_reset();
    @(negedge iClk); iRst = 1'b1;
    repeat (2) @(negedge iClk);
    iRst = 1'b0;
    model_reset();
    @(negedge iClk);
  endtask

  task automatic io_write(input logic a0, input logic [7:0] d);
    model_write(a0, d);
    @(negedge iClk); iCS = 1'b1; iWR = 1'b1; iA0 = a0; iData = d;
    repeat (2) @(negedge iClk);
    iCS = 1'b0; iWR = 1'b0; iData = 8'd0;
    @(negedge iClk);
  endtask

  task automatic io_read(input logic a0, input string tag);
    exp_q.push_back(a0 ? m_imr : (m_rsel ? m_isr : m_irr));
    @(negedge iClk); iCS = 1'b1; iRD = 1'b1; iA0 = a0;
    repeat (2) @(negedge iClk);
    sb_check(tag, oData);
    iCS = 1'b0; iRD = 1'b0;
    @(negedge iClk);
  endtask

  task automatic irq_pulse(input logic [7:0] mask);
    m_irr = m_irr | mask;
    @(negedge iClk); iIrq = mask;
    repeat (2) @(negedge iClk);
    iIrq = 8'd0;
    @(negedge iClk);
  endtask

  task automatic check_int(input string tag);
    exp_q.push_back({7'd0, model_int()});
    repeat (3) @(negedge iClk);
    sb_check(tag, {7'd0, oInt});
  endtask

  task automatic inta_pulse1();
    logic [7:0] pend;
    pend = m_irr & ~m_imr;
    if (pend == 8'd0) begin
      m_n = 3'd7; m_spur = 1'b1;
    end else begin
      m_spur = 1'b0;
      for (int i = 7; i >= 0; i--) if (pend[i]) m_n = 3'(i);
      m_isr[m_n] = 1'b1;
      m_irr[m_n] = 1'b0;
    end
    exp_q.push_back({m_base, m_n});
    @(negedge iClk); iIntA = 1'b0;
    repeat (2) @(negedge iClk);
    iIntA = 1'b1;
    repeat (2) @(negedge iClk);
  endtask

  task automatic inta_pulse2(input string tag);
    @(negedge iClk); iIntA = 1'b0;
    repeat (3) @(negedge iClk);
    sb_check(tag, oData);
    iIntA = 1'b1;
    if (m_aeoi && !m_spur) m_isr[m_n] = 1'b0;
    repeat (3) @(negedge iClk);
  endtask

  task automatic inta_seq(input string tag);
    inta_pulse1();
    inta_pulse2(tag);
  endtask

  initial begin
    model_reset();
    do_reset();
    exp_q.push_back(8'd0);
    sb_check("reset_odata", oData);
    check_int("reset_int");
    io_read(1'b1, "reset_imr");
    io_read(1'b0, "reset_irr");

    // 1: basic init and single IRQ
    io_write(1'b0, 8'h13);
    io_write(1'b1, 8'h08);
    io_write(1'b1, 8'h09);
    io_write(1'b1, 8'hFE);
    irq_pulse(8'h01);
    check_int("t1_int_up");
    inta_seq("t1_vector");
    check_int("t1_int_down");
    io_write(1'b0, 8'h0B);
    io_read(1'b0, "t1_isr");
    io_write(1'b0, 8'h20);

    // 2: simultaneous IRQ1/IRQ3, priority and EOI
    io_write(1'b1, 8'h00);
    irq_pulse(8'h0A);
    check_int("t2_int_up");
    inta_seq("t2_vec1");
    io_read(1'b0, "t2_isr");
    check_int("t2_int_blocked");
    io_write(1'b0, 8'h20);
    check_int("t2_int_after_eoi");
    inta_seq("t2_vec3");

    // 3: nesting with ISR=0x08
    irq_pulse(8'h20);
    check_int("t3_irq5_lower");
    irq_pulse(8'h04);
    check_int("t3_irq2_higher");
    inta_seq("t3_vec2");
    io_write(1'b0, 8'h40);
    io_read(1'b0, "t3_isr_noop");
    io_write(1'b0, 8'h63);
    io_read(1'b0, "t3_isr_specific");
    io_write(1'b0, 8'h20);
    check_int("t3_irq5_now");
    inta_seq("t3_vec5");
    io_write(1'b0, 8'h20);

    // 4: register reads
    io_write(1'b1, 8'hFF);
    irq_pulse(8'h81);
    check_int("t4_masked");
    io_write(1'b0, 8'h0A);
    io_read(1'b0, "t4_irr");
    io_write(1'b0, 8'h0B);
    io_read(1'b0, "t4_isr");
    io_write(1'b0, 8'h08);
    io_read(1'b0, "t4_isr_kept");
    io_read(1'b1, "t4_imr");

    // 5: cascade-style init with ICW3, AEOI, spurious ack
    io_write(1'b0, 8'h11);
    io_write(1'b1, 8'h20);
    io_write(1'b0, 8'h0B);
    io_write(1'b1, 8'h00);
    io_write(1'b1, 8'h0B);
    irq_pulse(8'h10);
    io_read(1'b0, "t5_irr");
    check_int("t5_int_up");
    inta_seq("t5_vec4");
    io_write(1'b0, 8'h0B);
    io_read(1'b0, "t5_isr_aeoi");
    inta_seq("t5_spurious");
    io_read(1'b0, "t5_isr_spur");
    check_int("t5_int_idle");

    // 6: reset between INTA pulses
    irq_pulse(8'h06);
    inta_pulse1();
    do_reset();
    check_int("t6_int_reset");
    io_read(1'b1, "t6_imr");
    io_read(1'b0, "t6_irr");
    io_write(1'b0, 8'h0B);
    io_read(1'b0, "t6_isr");
    io_write(1'b1, 8'h00);
    irq_pulse(8'h40);
    check_int("t6_int_up");
    inta_seq("t6_vec_fresh");
    check_int("t6_int_down");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
